// File: rtl/seg7_mux_driver_if.sv
// Bus between a display producer and the multiplexed seven-segment driver.
// The producer loads digit values; the driver returns active-low segment and enable lines.
interface seg7_mux_driver_if #(
  parameter int NUM_DIGITS = 3
);
  logic [4*NUM_DIGITS-1:0] D;
  logic [NUM_DIGITS-1:0]   DP;
  logic [NUM_DIGITS-1:0]   BLANK;
  logic                    LOAD;
  logic [7:0]              SEG;
  logic [NUM_DIGITS-1:0]   EN;

  modport master (
    output D, DP, BLANK, LOAD,
    input  SEG, EN
  );

  modport slave (
    input  D, DP, BLANK, LOAD,
    output SEG, EN
  );
endinterface

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed seven-segment driver with frame-synchronous display updates,
// optional hex decode, per-digit blanking and leading-zero suppression.
module seg7_mux_driver #(
  parameter int NUM_DIGITS  = 3,
  parameter int CLK_DIV     = 16000,
  parameter int HEX_MODE    = 1,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic             CLK,
  input  logic             RST,
  seg7_mux_driver_if.slave bus
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic                  r_pend;
  logic [DW-1:0]         r_hold_d;
  logic [NUM_DIGITS-1:0] r_hold_dp;
  logic [NUM_DIGITS-1:0] r_hold_bl;
  logic [DW-1:0]         r_disp_d;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic [NUM_DIGITS-1:0] r_disp_bl;
  logic [7:0]            r_seg_p1;
  logic [NUM_DIGITS-1:0] r_en_p1;

  logic                  w_tick;
  logic                  w_frame;
  logic [3:0]            w_code;
  logic                  w_dp;
  logic                  w_bl;
  logic                  w_lz;
  logic [NUM_DIGITS-1:0] w_lz_vec;
  logic [7:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_en_next;

  // Segment pattern {a..g} for a 4-bit code, dp appended as active-low bit 0.
  function automatic logic [7:0] seg_decode(input logic [3:0] code, input logic dp);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'b0000001;
      4'h1:    pat = 7'b1001111;
      4'h2:    pat = 7'b0010010;
      4'h3:    pat = 7'b0000110;
      4'h4:    pat = 7'b1001100;
      4'h5:    pat = 7'b0100100;
      4'h6:    pat = 7'b0100000;
      4'h7:    pat = 7'b0001111;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0000100;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b1100000;
      4'hC:    pat = 7'b0110001;
      4'hD:    pat = 7'b1000010;
      4'hE:    pat = 7'b0110000;
      default: pat = 7'b0111000;
    endcase
    if (HEX_MODE == 0 && code > 4'd9) begin
      return 8'hFE;
    end
    return {pat, ~dp};
  endfunction

  assign w_tick  = (r_presc == PRESC_LAST);
  assign w_frame = w_tick && (r_idx == IDX_LAST);

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic v_zero;
    w_lz_vec = '0;
    v_zero   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      v_zero      = v_zero & (r_disp_d[4*k +: 4] == 4'd0);
      w_lz_vec[k] = v_zero;
    end
  end

  always_comb begin
    w_code    = '0;
    w_dp      = 1'b0;
    w_bl      = 1'b0;
    w_lz      = 1'b0;
    w_en_next = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_code       = r_disp_d[4*k +: 4];
        w_dp         = r_disp_dp[k];
        w_bl         = r_disp_bl[k];
        w_lz         = w_lz_vec[k];
        w_en_next[k] = 1'b0;
      end
    end
  end

  assign w_seg_next = (w_bl || (LZ_SUPPRESS != 0 && w_lz)) ? 8'hFF : seg_decode(w_code, w_dp);

  // Stage p0: prescaler, digit index, holding and display registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc   <= '0;
      r_idx     <= '0;
      r_pend    <= 1'b0;
      r_hold_d  <= '0;
      r_hold_dp <= '0;
      r_hold_bl <= '0;
      r_disp_d  <= '0;
      r_disp_dp <= '0;
      r_disp_bl <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      if (bus.LOAD) begin
        r_hold_d  <= bus.D;
        r_hold_dp <= bus.DP;
        r_hold_bl <= bus.BLANK;
      end
      // Display only changes on a frame boundary so a frame never tears.
      if (w_frame) begin
        if (bus.LOAD) begin
          r_disp_d  <= bus.D;
          r_disp_dp <= bus.DP;
          r_disp_bl <= bus.BLANK;
        end else if (r_pend) begin
          r_disp_d  <= r_hold_d;
          r_disp_dp <= r_hold_dp;
          r_disp_bl <= r_hold_bl;
        end
        r_pend <= 1'b0;
      end else if (bus.LOAD) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Stage p1: registered segment and enable outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_seg_p1 <= 8'hFF;
      r_en_p1  <= '1;
    end else begin
      r_seg_p1 <= w_seg_next;
      r_en_p1  <= w_en_next;
    end
  end

  assign bus.SEG = r_seg_p1;
  assign bus.EN  = r_en_p1;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver: four parameter variants driven from one stimulus stream,
// compared each cycle against a frame-level reference model plus fixed-value scenarios.
module tb_seg7_mux_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] tb_d  = '0;
  logic [2:0]  tb_dp = '0;
  logic [2:0]  tb_bl = '0;
  logic        tb_ld = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  seg7_mux_driver_if #(.NUM_DIGITS(3)) if_a ();
  seg7_mux_driver_if #(.NUM_DIGITS(3)) if_h ();
  seg7_mux_driver_if #(.NUM_DIGITS(3)) if_z ();
  seg7_mux_driver_if #(.NUM_DIGITS(1)) if_1 ();

  assign if_a.D = tb_d;  assign if_a.DP = tb_dp;  assign if_a.BLANK = tb_bl;  assign if_a.LOAD = tb_ld;
  assign if_h.D = tb_d;  assign if_h.DP = tb_dp;  assign if_h.BLANK = tb_bl;  assign if_h.LOAD = tb_ld;
  assign if_z.D = tb_d;  assign if_z.DP = tb_dp;  assign if_z.BLANK = tb_bl;  assign if_z.LOAD = tb_ld;
  assign if_1.D = tb_d[3:0];  assign if_1.DP = tb_dp[0];  assign if_1.BLANK = tb_bl[0];  assign if_1.LOAD = tb_ld;

  seg7_mux_driver #(.NUM_DIGITS(3), .CLK_DIV(4), .HEX_MODE(1), .LZ_SUPPRESS(0))
    dut_a (.CLK(clk), .RST(rst), .bus(if_a));
  seg7_mux_driver #(.NUM_DIGITS(3), .CLK_DIV(4), .HEX_MODE(0), .LZ_SUPPRESS(0))
    dut_h (.CLK(clk), .RST(rst), .bus(if_h));
  seg7_mux_driver #(.NUM_DIGITS(3), .CLK_DIV(4), .HEX_MODE(1), .LZ_SUPPRESS(1))
    dut_z (.CLK(clk), .RST(rst), .bus(if_z));
  seg7_mux_driver #(.NUM_DIGITS(1), .CLK_DIV(2), .HEX_MODE(1), .LZ_SUPPRESS(1))
    seg7_mux_driver_1 (.CLK(clk), .RST(rst), .bus(if_1));

  logic [7:0] a_seg [4];
  logic [7:0] a_en  [4];
  assign a_seg[0] = if_a.SEG;  assign a_en[0] = {5'b0, if_a.EN};
  assign a_seg[1] = if_h.SEG;  assign a_en[1] = {5'b0, if_h.EN};
  assign a_seg[2] = if_z.SEG;  assign a_en[2] = {5'b0, if_z.EN};
  assign a_seg[3] = if_1.SEG;  assign a_en[3] = {7'b0, if_1.EN};

  // Reference model: slots of DIV cycles, frames of DIV*N cycles; the display adopts the
  // last value loaded during a frame at the edge that ends that frame.
  logic [7:0] SEGTBL [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  int ugrp [4] = '{0, 0, 0, 1};
  int uhex [4] = '{1, 0, 1, 1};
  int ulz  [4] = '{0, 0, 1, 1};
  int gn   [2] = '{3, 1};
  int gdiv [2] = '{4, 2};

  int          m_j   [2];
  logic [31:0] m_dd  [2];
  logic [31:0] m_hd  [2];
  logic [7:0]  m_ddp [2];
  logic [7:0]  m_dbl [2];
  logic [7:0]  m_hdp [2];
  logic [7:0]  m_hbl [2];
  bit          m_pend[2];
  logic [7:0]  e_seg [4];
  logic [7:0]  e_en  [4];

  function automatic logic [7:0] mseg(logic [31:0] d, logic [7:0] dp, logic [7:0] bl,
                                      int k, int hex, int lz);
    int code;
    code = int'((d >> (4 * k)) & 32'hF);
    if (bl[k]) return 8'hFF;
    if (lz != 0 && k > 0 && (d >> (4 * k)) == 32'd0) return 8'hFF;
    if (hex == 0 && code > 9) return 8'hFE;
    return (SEGTBL[code] & 8'hFE) | {7'b0, ~dp[k]};
  endfunction

  initial begin
    int mi;
    for (int g = 0; g < 2; g++) begin
      m_j[g] = 0; m_dd[g] = '0; m_ddp[g] = '0; m_dbl[g] = '0;
      m_hd[g] = '0; m_hdp[g] = '0; m_hbl[g] = '0; m_pend[g] = 1'b0;
    end
    for (int u = 0; u < 4; u++) begin
      e_seg[u] = 8'hFF;
      e_en[u]  = (ugrp[u] == 0) ? 8'h07 : 8'h01;
    end
    forever begin
      @(posedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          m_j[g] = 0; m_dd[g] = '0; m_ddp[g] = '0; m_dbl[g] = '0; m_pend[g] = 1'b0;
        end else begin
          mi = (m_j[g] / gdiv[g]) % gn[g];
          for (int u = 0; u < 4; u++) begin
            if (ugrp[u] == g) begin
              e_seg[u] = mseg(m_dd[g], m_ddp[g], m_dbl[g], mi, uhex[u], ulz[u]);
              e_en[u]  = 8'((~(32'd1 << mi)) & ((32'd1 << gn[g]) - 32'd1));
            end
          end
          m_j[g]++;
          if (tb_ld) begin
            m_hd[g] = {20'b0, tb_d}; m_hdp[g] = {5'b0, tb_dp}; m_hbl[g] = {5'b0, tb_bl};
            m_pend[g] = 1'b1;
          end
          if (m_j[g] % (gdiv[g] * gn[g]) == 0) begin
            if (m_pend[g]) begin
              m_dd[g] = m_hd[g]; m_ddp[g] = m_hdp[g]; m_dbl[g] = m_hbl[g];
            end
            m_pend[g] = 1'b0;
          end
        end
      end
      if (rst) begin
        for (int u = 0; u < 4; u++) begin
          e_seg[u] = 8'hFF;
          e_en[u]  = (ugrp[u] == 0) ? 8'h07 : 8'h01;
        end
      end
    end
  end

  task automatic load_val(input logic [11:0] d, input logic [2:0] dp, input logic [2:0] bl);
    tb_d = d; tb_dp = dp; tb_bl = bl; tb_ld = 1'b1;
    @(negedge clk);
    tb_ld = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int w = 0; w < 24 && (m_j[0] % 12) != ph; w++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; tb_ld = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (if_a.SEG !== 8'hFF || if_a.EN !== 3'b111) begin
      n_errors++;
      $display("FAIL reset_hold: seg=%h en=%b, expected seg=ff en=111", if_a.SEG, if_a.EN);
    end
    n_checks++;
    if (if_1.SEG !== 8'hFF || if_1.EN !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_hold_n1: seg=%h en=%b, expected seg=ff en=1", if_1.SEG, if_1.EN);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_a.SEG !== 8'h03 || if_a.EN !== 3'b110 || if_z.SEG !== 8'h03) begin
      n_errors++;
      $display("FAIL reset_first: seg=%h en=%b zseg=%h, expected seg=03 en=110 zseg=03",
               if_a.SEG, if_a.EN, if_z.SEG);
    end
    n_checks++;
    if (if_1.SEG !== 8'h03 || if_1.EN !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_first_n1: seg=%h en=%b, expected seg=03 en=0", if_1.SEG, if_1.EN);
    end
  endtask

  task automatic test_scan;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      for (int u = 0; u < 4; u++) begin
        n_checks++;
        if (a_seg[u] !== e_seg[u] || a_en[u] !== e_en[u]) begin
          n_errors++;
          $display("FAIL scan u%0d t=%0t: seg=%h en=%b, expected seg=%h en=%b",
                   u, $time, a_seg[u], a_en[u], e_seg[u], e_en[u]);
        end
      end
      n_checks++;
      if (if_a.SEG !== 8'h03) begin
        n_errors++;
        $display("FAIL scan_seg t=%0t: seg=%h, expected 03", $time, if_a.SEG);
      end
    end
  endtask

  task automatic test_frame_sync;
    wait_phase(5);
    load_val(12'h9A5, 3'b010, 3'b000);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int u = 0; u < 4; u++) begin
        n_checks++;
        if (a_seg[u] !== e_seg[u] || a_en[u] !== e_en[u]) begin
          n_errors++;
          $display("FAIL frame_sync u%0d t=%0t: seg=%h en=%b, expected seg=%h en=%b",
                   u, $time, a_seg[u], a_en[u], e_seg[u], e_en[u]);
        end
      end
    end
    for (int c = 0; c < 12; c++) begin
      logic [7:0] exp_s;
      @(negedge clk);
      exp_s = (if_a.EN == 3'b110) ? 8'h49 : (if_a.EN == 3'b101) ? 8'h10 : 8'h09;
      n_checks++;
      if (if_a.SEG !== exp_s) begin
        n_errors++;
        $display("FAIL frame_sync_val en=%b: seg=%h, expected %h", if_a.EN, if_a.SEG, exp_s);
      end
    end
  endtask

  task automatic test_hex;
    load_val(12'h0F0, 3'b000, 3'b000);
    repeat (24) @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if_a.EN == 3'b101) begin
        n_checks++;
        if (if_a.SEG !== 8'h71 || if_h.SEG !== 8'hFE) begin
          n_errors++;
          $display("FAIL hex_mode: hex1 seg=%h hex0 seg=%h, expected 71 and fe", if_a.SEG, if_h.SEG);
        end
      end
    end
  endtask

  task automatic test_lz;
    load_val(12'h007, 3'b000, 3'b000);
    repeat (24) @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks++;
      if (if_z.SEG !== ((if_z.EN == 3'b110) ? 8'h1F : 8'hFF) ||
          !(if_z.EN inside {3'b110, 3'b101, 3'b011})) begin
        n_errors++;
        $display("FAIL lz_007 en=%b: seg=%h, expected %s", if_z.EN, if_z.SEG,
                 (if_z.EN == 3'b110) ? "1f" : "ff with one enable low");
      end
    end
    load_val(12'h000, 3'b000, 3'b000);
    repeat (24) @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks++;
      if (if_z.SEG !== ((if_z.EN == 3'b110) ? 8'h03 : 8'hFF)) begin
        n_errors++;
        $display("FAIL lz_000 en=%b: seg=%h, expected %s", if_z.EN, if_z.SEG,
                 (if_z.EN == 3'b110) ? "03" : "ff");
      end
    end
  endtask

  task automatic test_boundary_load;
    wait_phase(11);
    load_val(12'h321, 3'b000, 3'b000);
    n_checks++;
    if (if_a.SEG !== 8'h03 || if_a.EN !== 3'b011) begin
      n_errors++;
      $display("FAIL boundary_last_slot: seg=%h en=%b, expected seg=03 en=011", if_a.SEG, if_a.EN);
    end
    @(negedge clk);
    n_checks++;
    if (if_a.SEG !== 8'h9F || if_a.EN !== 3'b110 || if_z.SEG !== 8'h9F) begin
      n_errors++;
      $display("FAIL boundary_next_slot: seg=%h en=%b zseg=%h, expected seg=9f en=110 zseg=9f",
               if_a.SEG, if_a.EN, if_z.SEG);
    end
  endtask

  task automatic test_blank;
    load_val(12'h888, 3'b100, 3'b100);
    repeat (24) @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks++;
      if (if_a.SEG !== ((if_a.EN == 3'b011) ? 8'hFF : 8'h01)) begin
        n_errors++;
        $display("FAIL blank en=%b: seg=%h, expected %s", if_a.EN, if_a.SEG,
                 (if_a.EN == 3'b011) ? "ff" : "01");
      end
    end
  endtask

  task automatic test_reset_pending;
    wait_phase(5);
    load_val(12'h456, 3'b111, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (if_a.SEG !== 8'hFF || if_a.EN !== 3'b111 || if_1.SEG !== 8'hFF || if_1.EN !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_pulse: seg=%h en=%b n1 seg=%h en=%b, expected ff/111 and ff/1",
               if_a.SEG, if_a.EN, if_1.SEG, if_1.EN);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int u = 0; u < 4; u++) begin
        n_checks++;
        if (a_seg[u] !== e_seg[u] || a_en[u] !== e_en[u]) begin
          n_errors++;
          $display("FAIL reset_pending u%0d t=%0t: seg=%h en=%b, expected seg=%h en=%b",
                   u, $time, a_seg[u], a_en[u], e_seg[u], e_en[u]);
        end
      end
      n_checks++;
      if (if_a.SEG !== 8'h03) begin
        n_errors++;
        $display("FAIL reset_pending_val t=%0t: seg=%h, expected 03", $time, if_a.SEG);
      end
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 800; c++) begin
      tb_ld = ($urandom_range(0, 5) == 0);
      if (tb_ld) begin
        tb_d  = 12'($urandom);
        tb_dp = 3'($urandom);
        tb_bl = 3'($urandom & $urandom);
        if ($urandom_range(0, 2) == 0) tb_d[11:8] = 4'd0;
        if ($urandom_range(0, 3) == 0) tb_d[7:4] = 4'd0;
      end
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      for (int u = 0; u < 4; u++) begin
        n_checks++;
        if (a_seg[u] !== e_seg[u] || a_en[u] !== e_en[u]) begin
          n_errors++;
          $display("FAIL random u%0d t=%0t: seg=%h en=%b, expected seg=%h en=%b",
                   u, $time, a_seg[u], a_en[u], e_seg[u], e_en[u]);
        end
      end
    end
    tb_ld = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_scan;
    test_frame_sync;
    test_hex;
    test_lz;
    test_boundary_load;
    test_blank;
    test_reset_pending;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/seg7_mux_driver.md
SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 3, sets the number of multiplexed digits (legal range 1..8).
REQ-002 Parameter CLK_DIV, default 16000, sets the number of CLK cycles per digit slot (legal range 2..2^20).
REQ-003 Parameter HEX_MODE, default 1: 1 = codes 10..15 shown as A,b,C,d,E,F; 0 = codes 10..15 shown as error pattern 8'b11111110.
REQ-004 Parameter LZ_SUPPRESS, default 0: 1 = leading zero digits blanked.
REQ-005 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-006 RST  input  1  reset, synchronous and active-high.
REQ-007 D  input  4*NUM_DIGITS  BCD/hex value; D[3:0] is digit 0, the rightmost and least significant digit.
REQ-008 DP  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-009 BLANK  input  NUM_DIGITS  per-digit blank request, 1 = all segments off including DP.
REQ-010 LOAD  input  1  single-cycle strobe capturing D, DP and BLANK into the holding register.
REQ-011 SEG  output  8  registered segments {a,b,c,d,e,f,g,dp}, active-low.
REQ-012 EN  output  NUM_DIGITS  registered digit enables, active-low, at most one bit low.

Function
REQ-013 Segment codes 0..9 SHALL be 03,9F,25,0D,99,49,41,1F,01,09 (hex, bits 7:1); codes A..F SHALL be 11,C1,63,85,61,71; SEG[0] = ~DP of the digit.
REQ-014 Prescaler counts 0..CLK_DIV-1 and wraps; tick = 1 in the cycle the count equals CLK_DIV-1.
REQ-015 Digit index idx counts 0..NUM_DIGITS-1; on tick it increments and wraps from NUM_DIGITS-1 to 0.
REQ-016 Every cycle: SEG <= decode(display[idx]) and EN <= ~(1 << idx), giving 1-cycle latency from idx to the outputs.
REQ-017 LOAD = 1 copies D/DP/BLANK into holding and sets pending.
REQ-018 Frame boundary = tick with idx = NUM_DIGITS-1; at the boundary the display register loads holding when pending = 1, then pending clears.
REQ-019 LOAD coincident with a frame boundary loads D/DP/BLANK directly into display and leaves pending = 0.
REQ-020 LOAD between boundaries: last LOAD wins; display never changes mid-frame (no tearing).
REQ-021 Blanked digit (BLANK bit, or LZ suppression): SEG = 8'hFF while its EN bit is still driven low.
REQ-022 LZ_SUPPRESS = 1: digit k is suppressed if it and all digits above it are 0; digit 0 is never suppressed; suppression ignores DP.
REQ-023 Precedence: BLANK > LZ suppression > HEX_MODE decode.
REQ-024 Prescaler width = clog2(CLK_DIV) bits; idx width = max(1, clog2(NUM_DIGITS)) bits; no overflow past the wrap values.
REQ-025 NUM_DIGITS = 1: EN constantly 1'b0 after the first post-reset cycle; every tick is a frame boundary.

Reset
REQ-026 RST = 1 SHALL force SEG = 8'hFF, all EN bits 1, prescaler 0, idx 0, holding and display all 0 (BLANK 0, DP 0), and pending 0 on the next edge; RST takes precedence over LOAD and tick.
REQ-027 First cycle after RST release: SEG = 8'h03 (or 8'hFF if LZ_SUPPRESS and digit index > 0), EN = ~1.
REQ-028 RST asserted mid-frame or mid-load SHALL discard the pending data.

Verification (NUM_DIGITS=3, CLK_DIV=4 unless stated)
REQ-029 Scan: release RST, hold for 24 cycles -> EN sequence 110,101,011 repeating, each held 4 cycles; SEG = 8'h03 throughout.
REQ-030 Frame-sync load: LOAD with D = 12'h9A5, DP = 3'b010 while idx = 1 -> display unchanged until idx wraps to 0; then digit0 SEG = 49, digit1 SEG = 10, digit2 SEG = 09.
REQ-031 HEX_MODE = 0 with D = 12'h0F0 -> digit1 SEG = 8'hFE; HEX_MODE = 1 -> digit1 SEG = 8'h71.
REQ-032 LZ_SUPPRESS = 1 with D = 12'h007 -> digits 2 and 1 SEG = FF with their EN low, digit0 SEG = 1F; D = 12'h000 -> digit0 SEG = 03.
REQ-033 Edge cases: LOAD on the boundary tick -> new value shown in the very next slot; BLANK = 3'b100 -> digit2 SEG = FF even with DP set.
REQ-034 RST pulsed 1 cycle mid-slot after a pending LOAD -> outputs FF/111 for that cycle, then 0 displayed and the pending value never appears.
